writeback_queue: RTL and testbench

- Writeback buffer between the ALU result path and the register-file write port (WriteEn/WriteRegNum/RegData).
- Accepts ALU results on a valid/ready handshake and holds them in an in-order FIFO.
- Issues one register-file write per cycle unless the write port is held.
- Provides per-read-port forwarding so reads of pending registers return the newest queued value.

---
 rtl/writeback_queue.sv | 125 ++++++++++++
 tb/tb_writeback_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order ALU result writeback FIFO with per-port register forwarding.
// Optional WBQ_STATS_EN adds saturating DropCount/HoldCount statistics outputs.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [ADDR_W-1:0]        InRegNum,
    input  logic [DATA_W-1:0]        InData,
    input  logic                     WbHold,
    output logic                     WriteEn,
    output logic [ADDR_W-1:0]        WriteRegNum,
    output logic [DATA_W-1:0]        RegData,
    input  logic [ADDR_W-1:0]        ReadRegNum1,
    input  logic [ADDR_W-1:0]        ReadRegNum2,
    output logic                     Fwd1Hit,
    output logic [DATA_W-1:0]        Fwd1Data,
    output logic                     Fwd2Hit,
    output logic [DATA_W-1:0]        Fwd2Data,
    output logic [$clog2(DEPTH):0]   Count
`ifdef WBQ_STATS_EN
    ,
    output logic [15:0]              DropCount,
    output logic [15:0]              HoldCount
`endif
);
    localparam int ptrW = $clog2(DEPTH);
    localparam int cntW = ptrW + 1;

    logic [ADDR_W-1:0] regNumMem [DEPTH];
    logic [DATA_W-1:0] dataMem   [DEPTH];
    logic [ptrW-1:0]   headPtr;
    logic [ptrW-1:0]   tailPtr;
    logic [cntW-1:0]   countReg;
    logic              acceptEn;
    logic              pushEn;
    logic              popEn;

    assign InReady  = Rst_n && (countReg < cntW'(DEPTH));
    assign acceptEn = InValid && InReady;
    // Writes to r0 are architecturally discarded, so they never occupy an entry.
    assign pushEn   = acceptEn && (InRegNum != '0);
    assign popEn    = (countReg != '0) && !WbHold;
    assign Count    = countReg;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            headPtr     <= '0;
            tailPtr     <= '0;
            countReg    <= '0;
            WriteEn     <= 1'b0;
            WriteRegNum <= '0;
            RegData     <= '0;
        end else begin
            if (pushEn)
                tailPtr <= tailPtr + ptrW'(1);
            if (popEn) begin
                headPtr     <= headPtr + ptrW'(1);
                WriteRegNum <= regNumMem[headPtr];
                RegData     <= dataMem[headPtr];
            end
            WriteEn <= popEn;
            case ({pushEn, popEn})
                2'b10:   countReg <= countReg + cntW'(1);
                2'b01:   countReg <= countReg - cntW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (pushEn) begin
            regNumMem[tailPtr] <= InRegNum;
            dataMem[tailPtr]   <= InData;
        end
    end

    // Oldest candidate first so that younger matches overwrite older ones.
    function automatic logic [DATA_W:0] fwdLookup(input logic [ADDR_W-1:0] addr);
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [ptrW-1:0]   idx;
        hit  = WriteEn && (WriteRegNum == addr);
        data = hit ? RegData : '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = headPtr + ptrW'(i);
            if ((cntW'(i) < countReg) && (regNumMem[idx] == addr)) begin
                hit  = 1'b1;
                data = dataMem[idx];
            end
        end
        if (addr == '0) begin
            hit  = 1'b0;
            data = '0;
        end
        return {hit, data};
    endfunction

    always_comb begin
        {Fwd1Hit, Fwd1Data} = fwdLookup(ReadRegNum1);
        {Fwd2Hit, Fwd2Data} = fwdLookup(ReadRegNum2);
    end

`ifdef WBQ_STATS_EN
    logic dropEn;
    assign dropEn = acceptEn && (InRegNum == '0);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            DropCount <= '0;
            HoldCount <= '0;
        end else begin
            if (dropEn && (DropCount != 16'hFFFF))
                DropCount <= DropCount + 16'd1;
            if ((countReg != '0) && WbHold && (HoldCount != 16'hFFFF))
                HoldCount <= HoldCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - scoreboard bench for writeback_queue: ordering, latency, forwarding, drop, wrap, reset.
module tb_writeback_queue;
    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic [4:0]  InRegNum;
    logic [31:0] InData;
    logic        WbHold;
    logic        WriteEn;
    logic [4:0]  WriteRegNum;
    logic [31:0] RegData;
    logic [4:0]  ReadRegNum1;
    logic [4:0]  ReadRegNum2;
    logic        Fwd1Hit;
    logic [31:0] Fwd1Data;
    logic        Fwd2Hit;
    logic [31:0] Fwd2Data;
    logic [2:0]  Count;
`ifdef WBQ_STATS_EN
    logic [15:0] DropCount;
    logic [15:0] HoldCount;
`endif

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wrEntry_t;

    wrEntry_t sb[$];
    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .InValid(InValid), .InReady(InReady), .InRegNum(InRegNum), .InData(InData),
        .WbHold(WbHold),
        .WriteEn(WriteEn), .WriteRegNum(WriteRegNum), .RegData(RegData),
        .ReadRegNum1(ReadRegNum1), .ReadRegNum2(ReadRegNum2),
        .Fwd1Hit(Fwd1Hit), .Fwd1Data(Fwd1Data), .Fwd2Hit(Fwd2Hit), .Fwd2Data(Fwd2Data),
        .Count(Count)
`ifdef WBQ_STATS_EN
        , .DropCount(DropCount), .HoldCount(HoldCount)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge Clk) begin
        wrEntry_t e;
        if (WriteEn === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=reg %0d data %h required=no write", WriteRegNum, RegData);
            end else begin
                e = sb.pop_front();
                check("wb_reg", {27'b0, WriteRegNum}, {27'b0, e.r});
                check("wb_data", RegData, e.d);
            end
        end
    end

    task automatic doPush(input logic [4:0] r, input logic [31:0] d, input bit wantWrite, output bit acc);
        wrEntry_t e;
        InValid  = 1'b1;
        InRegNum = r;
        InData   = d;
        @(negedge Clk);
        acc = InReady;
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        if (acc && (r != 5'd0) && wantWrite) begin
            e.r = r;
            e.d = d;
            sb.push_back(e);
        end
    endtask

    initial begin
        bit acc;
        int k;
        int cyc;
        int w;
        wrEntry_t e;

        Rst_n = 1'b0; InValid = 1'b0; InRegNum = '0; InData = '0; WbHold = 1'b0;
        ReadRegNum1 = '0; ReadRegNum2 = '0;

        // Reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_inready", {31'b0, InReady}, 0);
        check("rst_writeen", {31'b0, WriteEn}, 0);
        check("rst_count", {29'b0, Count}, 0);
        check("rst_wregnum", {27'b0, WriteRegNum}, 0);
        check("rst_regdata", RegData, 0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // Single write and latency
        doPush(5'd5, 32'hDEADBEEF, 1'b1, acc);
        check("single_acc", {31'b0, acc}, 1);
        @(negedge Clk);
        check("single_we_n1", {31'b0, WriteEn}, 0);
        check("single_cnt_n1", {29'b0, Count}, 1);
        @(negedge Clk);
        check("single_we_n2", {31'b0, WriteEn}, 1);
        check("single_cnt_n2", {29'b0, Count}, 0);
        @(negedge Clk);
        check("single_we_n3", {31'b0, WriteEn}, 0);
        @(posedge Clk);
        #1;

        // Fill and stall
        WbHold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            doPush(5'(i), 32'(i * 32'h11), 1'b1, acc);
            check("fill_acc", {31'b0, acc}, 1);
        end
        @(negedge Clk);
        check("full_count", {29'b0, Count}, 4);
        check("full_inready", {31'b0, InReady}, 0);
        ReadRegNum1 = 5'd3;
        #1;
        check("full_fwd_hit", {31'b0, Fwd1Hit}, 1);
        check("full_fwd_data", Fwd1Data, 32'h33);
        @(posedge Clk);
        #1;
        doPush(5'd9, 32'h99, 1'b1, acc);
        check("fifth_rejected", {31'b0, acc}, 0);
        WbHold = 1'b0;
        @(posedge Clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("drain_we_burst", {31'b0, WriteEn}, 1);
        end
        @(negedge Clk);
        check("drain_we_end", {31'b0, WriteEn}, 0);
        check("drain_count", {29'b0, Count}, 0);
        @(posedge Clk);
        #1;

        // Forwarding priority, queue then output stage
        WbHold = 1'b1;
        doPush(5'd7, 32'hA, 1'b1, acc);
        doPush(5'd7, 32'hB, 1'b1, acc);
        ReadRegNum1 = 5'd7;
        ReadRegNum2 = 5'd0;
        @(negedge Clk);
        check("fwd1_hit", {31'b0, Fwd1Hit}, 1);
        check("fwd1_data", Fwd1Data, 32'hB);
        check("fwd2_hit", {31'b0, Fwd2Hit}, 0);
        check("fwd2_data", Fwd2Data, 0);
        @(posedge Clk);
        #1;
        WbHold = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("fwd_mixed_data", Fwd1Data, 32'hB);
        @(negedge Clk);
        check("fwd_outstage_hit", {31'b0, Fwd1Hit}, 1);
        check("fwd_outstage_data", Fwd1Data, 32'hB);
        @(negedge Clk);
        check("fwd_empty_hit", {31'b0, Fwd1Hit}, 0);
        check("fwd_empty_data", Fwd1Data, 0);
        @(posedge Clk);
        #1;

        // Zero register drop
        doPush(5'd0, 32'hFFFFFFFF, 1'b1, acc);
        check("drop_inready", {31'b0, acc}, 1);
        @(negedge Clk);
        check("drop_count", {29'b0, Count}, 0);
`ifdef WBQ_STATS_EN
        check("drop_stat", {16'b0, DropCount}, 1);
`endif
        repeat (3) @(posedge Clk);
        #1;

        // Wrap and concurrency
        k = 0;
        cyc = 0;
        InValid = 1'b1;
        while (k < 10 && cyc < 100) begin
            WbHold   = cyc[0];
            InRegNum = 5'(k + 1);
            InData   = 32'h100 + 32'(k);
            @(negedge Clk);
            acc = InReady;
            check("wrap_count_bound", {31'b0, (Count > 3'd4)}, 0);
            @(posedge Clk);
            #1;
            if (acc) begin
                e.r = InRegNum;
                e.d = InData;
                sb.push_back(e);
                k++;
            end
            cyc++;
        end
        InValid = 1'b0;
        WbHold  = 1'b0;
        check("wrap_all_accepted", k, 10);
        w = 0;
        while ((Count != 3'd0 || WriteEn) && w < 50) begin
            @(negedge Clk);
            w++;
        end
        check("wrap_drained", {29'b0, Count}, 0);
        check("wrap_sb_empty", sb.size(), 0);
        @(posedge Clk);
        #1;

        // Reset mid-operation
        WbHold = 1'b1;
        doPush(5'd21, 32'h2121, 1'b0, acc);
        doPush(5'd22, 32'h2222, 1'b0, acc);
        doPush(5'd23, 32'h2323, 1'b0, acc);
        ReadRegNum1 = 5'd21;
        ReadRegNum2 = 5'd22;
        @(negedge Clk);
        check("midrst_pre_count", {29'b0, Count}, 3);
        @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        @(negedge Clk);
        check("midrst_inready", {31'b0, InReady}, 0);
        @(posedge Clk);
        #1;
        Rst_n  = 1'b1;
        WbHold = 1'b0;
        @(negedge Clk);
        check("midrst_count", {29'b0, Count}, 0);
        check("midrst_we", {31'b0, WriteEn}, 0);
        check("midrst_fwd1", {31'b0, Fwd1Hit}, 0);
        check("midrst_fwd2", {31'b0, Fwd2Hit}, 0);
        repeat (6) @(posedge Clk);
        @(negedge Clk);
        check("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
